keypad_scan: RTL and testbench
==============================

Name: keypad_scan

Overview:
- Input-side counterpart of the multiplexed 4-digit display scan: drives the rows of a 4x4 matrix keypad one at a time (active-low) and samples the columns.
- Debounces the samples, rejects multi-key ghosts, and presents one 4-bit key code per press over a valid/ack handshake.
- Feeds operand entry for the signed multiplier datapath. It runs on the same slow_clock as the display scan.

Parameters:
- DEBOUNCE_SCANS, 4: number of consecutive identical full-matrix frames needed to accept a press or a release; legal range 1..15.
- SETTLE_CYCLES, 1: extra slow_clock cycles each row is driven before its columns are sampled. Row dwell R = SETTLE_CYCLES+1.

Ports:
- slow_clock  in   1  single clock; all flops update on its falling edge
- reset       in   1  asynchronous, active-low; clears all state
- COL         in   4  column sense, active-low (pulled up); bit n = column n
- key_ack     in   1  consumer accepts key_code when high while key_valid is high
- ROW         out  4  row drive, one-hot active-low; bit n = row n
- key_code    out  4  {row_idx[1:0], col_idx[1:0]} of the last reported key
- key_valid   out  1  new key_code available; held until acknowledged
- key_held    out  1  debounced "a key is currently down"
- overrun     out  1  sticky: a press was discarded because key_valid was unacknowledged

Behaviour:
- Reset values: ROW=4'b1110, key_code=0, key_valid=0, key_held=0, overrun=0, row_idx=0, dwell counter=0, debounce FSM=IDLE, candidate=0, count=0. Reset asserted mid-frame abandons the frame. Scanning restarts at row 0 on the first falling edge after release.
- Scan: ROW sequence is 1110, 1101, 1011, 0111, then wraps. Each row is driven for R cycles.
- COL is sampled on the last cycle of each row. The sample is pressed if any bit is 0.
- Per-row result is none, single (exactly one 0 bit, col_idx = its position), or multi.
- Frame result is taken at the ROW3 sample edge:
  - NONE if all rows are none.
  - KEY(k) if exactly one row is single and the rest are none.
  - MULTI otherwise.
- Frame = 4R cycles; defaults give 8.
- The debounce FSM advances only on frame-end edges. count saturates at DEBOUNCE_SCANS.
  - IDLE: KEY(k) -> PRESS_DEB with cand=k, count=1. NONE or MULTI -> stay.
  - PRESS_DEB:
    - KEY(cand) -> count+1.
    - KEY(other) -> cand=other, count=1.
    - NONE or MULTI -> IDLE.
    - When count reaches DEBOUNCE_SCANS -> report cand, go to HELD. With DEBOUNCE_SCANS=1 this is reported from IDLE directly.
  - HELD:
    - NONE -> RELEASE_DEB, count=1.
    - KEY(reported) or MULTI -> stay.
    - KEY(other) -> PRESS_DEB, cand=other, count=1.
  - RELEASE_DEB:
    - NONE -> count+1; at DEBOUNCE_SCANS -> IDLE.
    - KEY(reported) or MULTI -> HELD.
    - KEY(other) -> PRESS_DEB, cand=other, count=1.
- key_held = 1 in HELD or RELEASE_DEB; registered, updates on the frame-end edge.
- Report action, on the same edge as entering HELD:
  - key_valid=0, or key_ack=1 on that edge: load key_code=cand and set key_valid=1.
  - Otherwise: set overrun=1, keep key_code and key_valid unchanged, and still enter HELD.
- Handshake: key_ack=1 with key_valid=1 clears key_valid on that edge, unless a report happens on the same edge; then key_valid stays 1 with the new code. key_ack while key_valid=0 is ignored.
- Latency: a key stable from the start of a frame raises key_valid at the end of frame DEBOUNCE_SCANS, i.e. 4R*DEBOUNCE_SCANS cycles (32 with defaults).
- overrun clears only on reset.

Optional Feature:
- COL_SYNC_EN defined: COL passes through a two-flop synchronizer before sampling, and row dwell becomes R = SETTLE_CYCLES+3 so the sample reflects the current row. All frame and latency figures scale with the new R.
- COL_SYNC_EN undefined: COL is sampled directly and R = SETTLE_CYCLES+1.

Test Plan (defaults, COL_SYNC_EN undefined):
- Reset held low, then released -> all outputs at reset values. ROW then steps 1110,1110,1101,1101,1011,1011,0111,0111 and repeats with period 8.
- COL=1101 only while ROW=1011, held from frame start -> key_code=4'h9, key_valid=1 and key_held=1 at edge 32. key_ack pulse -> key_valid=0 on the next edge, key_held stays 1.
- Same key present in alternating frames only (bounce) for 10 frames -> key_valid never rises, key_held=0.
- Keys row0/col0 and row1/col3 pressed together for 8 frames -> no report, FSM stays IDLE. Then release row1/col3 -> key_code=4'h0 after 4 more frames.
- Report 4'h9 with no ack, release 4 frames, then press row0/col3 for 4 frames -> overrun=1, key_code still 9, key_held=1. key_ack -> key_valid=0, overrun stays 1.
- Press held 2 frames, then reset pulsed low -> all outputs cleared, ROW=1110. The same key needs 4 full frames after release before key_valid=1.

Source files
------------

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: active-low row drive, debounced single-key capture, valid/ack output.
// Optional macro COL_SYNC_EN adds a two-flop column synchronizer and stretches the row dwell to match.
module keypad_scan #(
  parameter int DEBOUNCE_SCANS = 4,
  parameter int SETTLE_CYCLES  = 1
) (
  input  logic       slow_clock,
  input  logic       reset,
  input  logic [3:0] COL,
  input  logic       key_ack,
  output logic [3:0] ROW,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held,
  output logic       overrun
);

`ifdef COL_SYNC_EN
  localparam int ROW_DWELL = SETTLE_CYCLES + 3;
`else
  localparam int ROW_DWELL = SETTLE_CYCLES + 1;
`endif
  localparam int DWELL_W = (ROW_DWELL > 1) ? $clog2(ROW_DWELL) : 1;
  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(ROW_DWELL - 1);
  localparam logic [3:0] DEB_MAX = 4'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {IDLE, PRESS_DEB, HELD, RELEASE_DEB} state_t;

  logic [3:0] col_sample;

`ifdef COL_SYNC_EN
  logic [3:0] col_meta_reg, col_sync_reg;
  always_ff @(negedge slow_clock or negedge reset) begin
    if (!reset) begin
      col_meta_reg <= 4'hF;
      col_sync_reg <= 4'hF;
    end else begin
      col_meta_reg <= COL;
      col_sync_reg <= col_meta_reg;
    end
  end
  assign col_sample = col_sync_reg;
`else
  assign col_sample = COL;
`endif

  logic [1:0]         row_idx_reg;
  logic [DWELL_W-1:0] dwell_reg;
  logic               sample_edge, frame_end;

  assign sample_edge = (dwell_reg == DWELL_LAST);
  assign frame_end   = sample_edge && (row_idx_reg == 2'd3);
  assign ROW         = ~(4'b0001 << row_idx_reg);

  always_ff @(negedge slow_clock or negedge reset) begin
    if (!reset) begin
      row_idx_reg <= 2'd0;
      dwell_reg   <= '0;
    end else if (sample_edge) begin
      row_idx_reg <= row_idx_reg + 2'd1;
      dwell_reg   <= '0;
    end else begin
      dwell_reg   <= dwell_reg + 1'b1;
    end
  end

  // Classify the current row's columns: none, exactly one, or several pressed.
  logic [3:0] col_pressed;
  logic [1:0] row_col;
  logic       row_single, row_multi;

  always_comb begin
    col_pressed = ~col_sample;
    row_single  = 1'b0;
    row_col     = 2'd0;
    case (col_pressed)
      4'b0001: begin row_single = 1'b1; row_col = 2'd0; end
      4'b0010: begin row_single = 1'b1; row_col = 2'd1; end
      4'b0100: begin row_single = 1'b1; row_col = 2'd2; end
      4'b1000: begin row_single = 1'b1; row_col = 2'd3; end
      default: ;
    endcase
    row_multi = (|col_pressed) && !row_single;
  end

  logic       acc_found_reg, acc_multi_reg;
  logic [3:0] acc_key_reg;
  logic       hit_found, hit_multi;
  logic [3:0] hit_key;
  logic       frame_key, frame_none;

  // A second single row anywhere in the frame turns it into a ghost/multi frame.
  assign hit_multi  = acc_multi_reg | row_multi | (acc_found_reg & row_single);
  assign hit_found  = acc_found_reg | row_single;
  assign hit_key    = row_single ? {row_idx_reg, row_col} : acc_key_reg;
  assign frame_key  = hit_found && !hit_multi;
  assign frame_none = !hit_found && !hit_multi;

  always_ff @(negedge slow_clock or negedge reset) begin
    if (!reset) begin
      acc_found_reg <= 1'b0;
      acc_multi_reg <= 1'b0;
      acc_key_reg   <= 4'd0;
    end else if (frame_end) begin
      acc_found_reg <= 1'b0;
      acc_multi_reg <= 1'b0;
      acc_key_reg   <= 4'd0;
    end else if (sample_edge) begin
      acc_found_reg <= hit_found;
      acc_multi_reg <= hit_multi;
      acc_key_reg   <= hit_key;
    end
  end

  state_t     state_reg, state_next;
  logic [3:0] cand_reg, cand_next;
  logic [3:0] count_reg, count_next, count_inc;
  logic       start_press, report;
  logic [3:0] key_code_reg, key_code_next;
  logic       key_valid_reg, key_valid_next;
  logic       overrun_reg, overrun_next;
  logic       key_held_reg, key_held_next;

  assign count_inc = (count_reg < DEB_MAX) ? count_reg + 4'd1 : count_reg;

  // cand_reg doubles as the reported key while in HELD / RELEASE_DEB.
  always_comb begin
    state_next  = state_reg;
    cand_next   = cand_reg;
    count_next  = count_reg;
    start_press = 1'b0;
    report      = 1'b0;
    if (frame_end) begin
      case (state_reg)
        IDLE: begin
          if (frame_key) start_press = 1'b1;
        end
        PRESS_DEB: begin
          if (frame_key && hit_key == cand_reg) begin
            count_next = count_inc;
            if (count_inc >= DEB_MAX) begin
              report     = 1'b1;
              state_next = HELD;
            end
          end else if (frame_key) begin
            start_press = 1'b1;
          end else begin
            state_next = IDLE;
            count_next = 4'd0;
          end
        end
        HELD: begin
          if (frame_none) begin
            count_next = 4'd1;
            state_next = (DEB_MAX <= 4'd1) ? IDLE : RELEASE_DEB;
          end else if (frame_key && hit_key != cand_reg) begin
            start_press = 1'b1;
          end
        end
        RELEASE_DEB: begin
          if (frame_none) begin
            count_next = count_inc;
            if (count_inc >= DEB_MAX) begin
              state_next = IDLE;
              count_next = 4'd0;
            end
          end else if (frame_key && hit_key != cand_reg) begin
            start_press = 1'b1;
          end else begin
            state_next = HELD;
          end
        end
        default: state_next = IDLE;
      endcase
    end
    if (start_press) begin
      cand_next  = hit_key;
      count_next = 4'd1;
      if (DEB_MAX <= 4'd1) begin
        report     = 1'b1;
        state_next = HELD;
      end else begin
        state_next = PRESS_DEB;
      end
    end
  end

  always_comb begin
    key_code_next  = key_code_reg;
    key_valid_next = key_valid_reg;
    overrun_next   = overrun_reg;
    if (report) begin
      if (!key_valid_reg || key_ack) begin
        key_code_next  = cand_next;
        key_valid_next = 1'b1;
      end else begin
        overrun_next   = 1'b1;
      end
    end else if (key_ack && key_valid_reg) begin
      key_valid_next = 1'b0;
    end
    key_held_next = (state_next == HELD) || (state_next == RELEASE_DEB);
  end

  always_ff @(negedge slow_clock or negedge reset) begin
    if (!reset) begin
      state_reg     <= IDLE;
      cand_reg      <= 4'd0;
      count_reg     <= 4'd0;
      key_code_reg  <= 4'd0;
      key_valid_reg <= 1'b0;
      overrun_reg   <= 1'b0;
      key_held_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cand_reg      <= cand_next;
      count_reg     <= count_next;
      key_code_reg  <= key_code_next;
      key_valid_reg <= key_valid_next;
      overrun_reg   <= overrun_next;
      key_held_reg  <= key_held_next;
    end
  end

  assign key_code  = key_code_reg;
  assign key_valid = key_valid_reg;
  assign overrun   = overrun_reg;
  assign key_held  = key_held_reg;

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan (default parameters, COL_SYNC_EN undefined); a keypad model drives COL from ROW.
module tb_keypad_scan;
  logic       slow_clock, reset, key_ack;
  logic [3:0] COL, ROW, key_code;
  logic       key_valid, key_held, overrun;
  logic [15:0] keys;  // bit r*4+c = key at row r, column c is down
  int check_count = 0;
  int pass_count  = 0;

  keypad_scan dut (
    .slow_clock(slow_clock), .reset(reset), .COL(COL), .key_ack(key_ack),
    .ROW(ROW), .key_code(key_code), .key_valid(key_valid),
    .key_held(key_held), .overrun(overrun)
  );

  initial begin
    slow_clock = 1'b1;
    forever #5 slow_clock = ~slow_clock;
  end

  always_comb begin
    COL = 4'hF;
    for (int r = 0; r < 4; r++)
      if (!ROW[r]) COL = COL & ~keys[r*4 +: 4];
  end

  task automatic tick(input int n);
    repeat (n) @(negedge slow_clock);
    #1;
  endtask

  // Leaves the bench at a rising edge just after release; the next falling edge is edge 1.
  task automatic do_reset();
    reset = 1'b0; keys = 16'h0; key_ack = 1'b0;
    repeat (2) @(posedge slow_clock);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    logic [3:0] row_seq [4];
    row_seq[0] = 4'b1110; row_seq[1] = 4'b1101; row_seq[2] = 4'b1011; row_seq[3] = 4'b0111;
    reset = 1'b0; keys = 16'h0; key_ack = 1'b0;
    @(posedge slow_clock);
    check_count++; if (ROW !== 4'b1110) $display("FAIL reset_row: got %b want 1110", ROW); else pass_count++;
    check_count++; if (key_code !== 4'h0) $display("FAIL reset_code: got %h want 0", key_code); else pass_count++;
    check_count++; if (key_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", key_valid); else pass_count++;
    check_count++; if (key_held !== 1'b0) $display("FAIL reset_held: got %b want 0", key_held); else pass_count++;
    check_count++; if (overrun !== 1'b0) $display("FAIL reset_overrun: got %b want 0", overrun); else pass_count++;
    @(posedge slow_clock);
    reset = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check_count++;
      if (ROW !== row_seq[(i/2)%4]) $display("FAIL row_seq[%0d]: got %b want %b", i, ROW, row_seq[(i/2)%4]);
      else pass_count++;
      @(posedge slow_clock);
    end
    $display("test_reset: ROW sequence walked, ROW=%b", ROW);
  endtask

  task automatic test_single_key();
    do_reset();
    keys = 16'h0200;  // row2/col1
    tick(31);
    check_count++; if (key_valid !== 1'b0) $display("FAIL single_early: got %b want 0", key_valid); else pass_count++;
    tick(1);
    check_count++; if (key_valid !== 1'b1) $display("FAIL single_valid: got %b want 1", key_valid); else pass_count++;
    check_count++; if (key_code !== 4'h9) $display("FAIL single_code: got %h want 9", key_code); else pass_count++;
    check_count++; if (key_held !== 1'b1) $display("FAIL single_held: got %b want 1", key_held); else pass_count++;
    key_ack = 1'b1;
    tick(1);
    key_ack = 1'b0;
    check_count++; if (key_valid !== 1'b0) $display("FAIL single_ack_valid: got %b want 0", key_valid); else pass_count++;
    check_count++; if (key_held !== 1'b1) $display("FAIL single_ack_held: got %b want 1", key_held); else pass_count++;
    keys = 16'h0;
    tick(30);
    check_count++; if (key_held !== 1'b1) $display("FAIL release_early_held: got %b want 1", key_held); else pass_count++;
    tick(1);
    check_count++; if (key_held !== 1'b0) $display("FAIL release_held: got %b want 0", key_held); else pass_count++;
    $display("test_single_key: key_code=%h key_valid=%b key_held=%b", key_code, key_valid, key_held);
  endtask

  task automatic test_bounce();
    do_reset();
    for (int f = 0; f < 10; f++) begin
      keys = (f % 2 == 0) ? 16'h0200 : 16'h0;
      tick(8);
      check_count++; if (key_valid !== 1'b0) $display("FAIL bounce_valid[%0d]: got %b want 0", f, key_valid); else pass_count++;
      check_count++; if (key_held !== 1'b0) $display("FAIL bounce_held[%0d]: got %b want 0", f, key_held); else pass_count++;
    end
    $display("test_bounce: key_valid=%b key_held=%b", key_valid, key_held);
  endtask

  task automatic test_multi();
    do_reset();
    keys = 16'h0081;  // row0/col0 and row1/col3
    for (int f = 0; f < 8; f++) begin
      tick(8);
      check_count++; if (key_valid !== 1'b0) $display("FAIL multi_valid[%0d]: got %b want 0", f, key_valid); else pass_count++;
      check_count++; if (key_held !== 1'b0) $display("FAIL multi_held[%0d]: got %b want 0", f, key_held); else pass_count++;
    end
    keys = 16'h0001;
    tick(31);
    check_count++; if (key_valid !== 1'b0) $display("FAIL multi_release_early: got %b want 0", key_valid); else pass_count++;
    tick(1);
    check_count++; if (key_valid !== 1'b1) $display("FAIL multi_release_valid: got %b want 1", key_valid); else pass_count++;
    check_count++; if (key_code !== 4'h0) $display("FAIL multi_release_code: got %h want 0", key_code); else pass_count++;
    $display("test_multi: key_code=%h key_valid=%b", key_code, key_valid);
  endtask

  task automatic test_overrun();
    do_reset();
    keys = 16'h0200;
    tick(32);
    check_count++; if (key_code !== 4'h9) $display("FAIL ovr_first_code: got %h want 9", key_code); else pass_count++;
    keys = 16'h0;
    tick(32);
    check_count++; if (key_held !== 1'b0) $display("FAIL ovr_released_held: got %b want 0", key_held); else pass_count++;
    keys = 16'h0008;  // row0/col3
    tick(31);
    check_count++; if (overrun !== 1'b0) $display("FAIL ovr_early: got %b want 0", overrun); else pass_count++;
    tick(1);
    check_count++; if (overrun !== 1'b1) $display("FAIL ovr_set: got %b want 1", overrun); else pass_count++;
    check_count++; if (key_code !== 4'h9) $display("FAIL ovr_code: got %h want 9", key_code); else pass_count++;
    check_count++; if (key_held !== 1'b1) $display("FAIL ovr_held: got %b want 1", key_held); else pass_count++;
    check_count++; if (key_valid !== 1'b1) $display("FAIL ovr_valid: got %b want 1", key_valid); else pass_count++;
    key_ack = 1'b1;
    tick(1);
    key_ack = 1'b0;
    check_count++; if (key_valid !== 1'b0) $display("FAIL ovr_ack_valid: got %b want 0", key_valid); else pass_count++;
    check_count++; if (overrun !== 1'b1) $display("FAIL ovr_sticky: got %b want 1", overrun); else pass_count++;
    $display("test_overrun: key_code=%h overrun=%b key_valid=%b", key_code, overrun, key_valid);
  endtask

  task automatic test_back_to_back();
    do_reset();
    keys = 16'h0200;
    tick(32);
    keys = 16'h0;
    tick(32);
    keys = 16'h0008;
    tick(31);
    key_ack = 1'b1;  // ack lands on the same edge as the second report
    tick(1);
    key_ack = 1'b0;
    check_count++; if (key_valid !== 1'b1) $display("FAIL b2b_valid: got %b want 1", key_valid); else pass_count++;
    check_count++; if (key_code !== 4'h3) $display("FAIL b2b_code: got %h want 3", key_code); else pass_count++;
    check_count++; if (overrun !== 1'b0) $display("FAIL b2b_overrun: got %b want 0", overrun); else pass_count++;
    $display("test_back_to_back: key_code=%h key_valid=%b overrun=%b", key_code, key_valid, overrun);
  endtask

  task automatic test_reset_mid();
    do_reset();
    keys = 16'h0200;
    tick(19);
    reset = 1'b0;
    #1;
    check_count++; if (ROW !== 4'b1110) $display("FAIL mid_row: got %b want 1110", ROW); else pass_count++;
    check_count++; if (key_valid !== 1'b0) $display("FAIL mid_valid: got %b want 0", key_valid); else pass_count++;
    check_count++; if (key_held !== 1'b0) $display("FAIL mid_held: got %b want 0", key_held); else pass_count++;
    repeat (2) @(posedge slow_clock);
    reset = 1'b1;
    tick(31);
    check_count++; if (key_valid !== 1'b0) $display("FAIL mid_early: got %b want 0", key_valid); else pass_count++;
    tick(1);
    check_count++; if (key_valid !== 1'b1) $display("FAIL mid_valid_after: got %b want 1", key_valid); else pass_count++;
    check_count++; if (key_code !== 4'h9) $display("FAIL mid_code: got %h want 9", key_code); else pass_count++;
    $display("test_reset_mid: key_code=%h key_valid=%b", key_code, key_valid);
  endtask

  initial begin
    reset = 1'b0; keys = 16'h0; key_ack = 1'b0;
    test_reset();
    test_single_key();
    test_bounce();
    test_multi();
    test_overrun();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", pass_count, check_count);
    $fatal(1);
  end
endmodule
